// File: rtl/cpu_trace_monitor_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the cpu_trace_monitor slice:
//   - state_e      : capture FSM states (IDLE/RUN/DONE/TIMEOUT)
//   - trace_rec_t  : packed trace record at the default widths
//                    {cycle[16], opcode[4], pc[32], alu[32], acc[32]}
//   - recWidth()   : record width for arbitrary PC/DATA/CYC widths
//   - *Offset()    : LSB position of each record field
//   - DROP_W       : width of the saturating drop counter
// ---------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int DROP_W = 16;
  localparam int OPC_W  = 4;

  // Record layout at the default widths; fields listed MSB first.
  typedef struct packed {
    logic [15:0] cycle;
    logic [3:0]  opcode;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] acc;
  } trace_rec_t;

  function automatic int recWidth(input int cycW, input int pcW, input int dataW);
    return cycW + OPC_W + pcW + 2 * dataW;
  endfunction

  // acc sits at bit 0; every other field stacks above it.
  function automatic int aluOffset(input int dataW);
    return dataW;
  endfunction

  function automatic int pcOffset(input int dataW);
    return 2 * dataW;
  endfunction

  function automatic int opcodeOffset(input int pcW, input int dataW);
    return 2 * dataW + pcW;
  endfunction

  function automatic int cycleOffset(input int pcW, input int dataW);
    return 2 * dataW + pcW + OPC_W;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor_if
// Show-ahead read port of the trace monitor.
//   rd_en    : host -> monitor, pop the head record
//   rd_valid : monitor -> host, FIFO non-empty
//   rd_data  : monitor -> host, head record (valid while rd_valid=1)
//   count    : monitor -> host, FIFO occupancy
// Modports: master = host/debug side, slave = monitor side.
// ---------------------------------------------------------------------------
interface cpu_trace_monitor_if
  import trace_pkg::*;
#(
  parameter int REC_W = recWidth(16, 32, 32),
  parameter int CNT_W = 5
);

  logic             rd_en;
  logic             rd_valid;
  logic [REC_W-1:0] rd_data;
  logic [CNT_W-1:0] count;

  modport master (output rd_en, input rd_valid, input rd_data, input count);
  modport slave  (input rd_en, output rd_valid, output rd_data, output count);

endinterface

// File: rtl/cpu_trace_monitor_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Show-ahead FIFO holding trace records.
//   clk, rst   : clock, asynchronous active-low reset
//   clear_i    : synchronous flush, wins over push/pop in the same cycle
//   push_i     : write data_i; accepted when not full or when popping too
//   pop_i      : drop the head; ignored while empty
//   data_o     : head entry (meaningful only while empty_o=0)
//   count_o    : occupancy, one bit wider than the pointer index
//   full_o, empty_o : status flags
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             popEff;
  logic             pushEff;

  // Pointers carry one extra MSB: equal index with differing MSB means full.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;
  assign data_o  = mem_q[rdPtr_q[AW-1:0]];

  // A pop frees the head slot on this edge, so a push into a full FIFO
  // can land in that same slot.
  assign popEff  = pop_i && !empty_o;
  assign pushEff = push_i && (!full_o || popEff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else if (clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pushEff) wrPtr_q <= wrPtr_q + 1'b1;
      if (popEff)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pushEff && !clear_i) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor
// Per-cycle execution trace capture beside cpu_top. While in RUN every cycle
// forms a record {cycle, opcode, pc, alu, acc} and pushes it into an on-chip
// FIFO; completion (pc_value >= END_PC) and no-progress timeout end the run,
// and the first parity error latches its PC.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : arm / re-arm pulse (ignored while RUN)
//   pc_value, opcode, alu_result, acc, parity_error : core observation
//   opcode_mask     : (TRACE_OPCODE_FILTER_EN only) per-opcode capture enable
//   rd              : show-ahead read port (cpu_trace_monitor_if.slave)
//   drop_cnt        : saturating count of records lost to a full FIFO
//   state           : FSM state (IDLE/RUN/DONE/TIMEOUT)
//   done, timeout   : sticky end-of-run flags
//   parity_seen, err_pc : sticky parity flag and PC of first error
//   cycle_cnt       : RUN cycles elapsed, also the record timestamp
// Build option: define TRACE_OPCODE_FILTER_EN to add the opcode_mask filter.
// ---------------------------------------------------------------------------
module cpu_trace_monitor
  import trace_pkg::*;
#(
  parameter int PC_W           = 32,
  parameter int DATA_W         = 32,
  parameter int CYC_W          = 16,
  parameter int DEPTH          = 16,
  parameter int END_PC         = 80,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PC_W-1:0]    pc_value,
  input  logic [3:0]         opcode,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  acc,
  input  logic               parity_error,
`ifdef TRACE_OPCODE_FILTER_EN
  input  logic [15:0]        opcode_mask,
`endif
  cpu_trace_monitor_if.slave rd,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic [1:0]         state,
  output logic               done,
  output logic               timeout,
  output logic               parity_seen,
  output logic [PC_W-1:0]    err_pc,
  output logic [CYC_W-1:0]   cycle_cnt
);

  localparam int REC_W   = recWidth(CYC_W, PC_W, DATA_W);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int OFF_ALU = aluOffset(DATA_W);
  localparam int OFF_PC  = pcOffset(DATA_W);
  localparam int OFF_OPC = opcodeOffset(PC_W, DATA_W);
  localparam int OFF_CYC = cycleOffset(PC_W, DATA_W);

  localparam logic [PC_W-1:0]  END_PC_V   = PC_W'(END_PC);
  localparam logic [CYC_W-1:0] CYCLE_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  logic [CYC_W-1:0]   cycleCnt_q;
  logic [CYC_W-1:0]   cycleCnt_d;
  logic [DROP_W-1:0]  dropCnt_q;
  logic               done_q;
  logic               timeout_q;
  logic               paritySeen_q;
  logic [PC_W-1:0]    errPc_q;

  logic [REC_W-1:0]   recWord;
  logic               maskHit;
  logic               capture;
  logic               armNow;
  logic               popReq;
  logic               dropNow;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CNT_W-1:0]   fifoCount;
  logic [REC_W-1:0]   fifoHead;

  // Record is stamped with the cycle count before this cycle's increment.
  always_comb begin
    recWord = '0;
    recWord[0       +: DATA_W] = acc;
    recWord[OFF_ALU +: DATA_W] = alu_result;
    recWord[OFF_PC  +: PC_W]   = pc_value;
    recWord[OFF_OPC +: OPC_W]  = opcode;
    recWord[OFF_CYC +: CYC_W]  = cycleCnt_q;
  end

`ifdef TRACE_OPCODE_FILTER_EN
  assign maskHit = opcode_mask[opcode];
`else
  assign maskHit = 1'b1;
`endif

  assign capture    = (state_q == RUN) && maskHit;
  assign armNow     = start && (state_q != RUN);
  assign popReq     = rd.rd_en && !fifoEmpty;
  assign dropNow    = capture && fifoFull && !popReq;
  assign cycleCnt_d = cycleCnt_q + CYC_W'(1);

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (armNow),
    .push_i  (capture),
    .pop_i   (rd.rd_en),
    .data_i  (recWord),
    .data_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Capture FSM with its counters and sticky flags. Completion is tested
  // before timeout so a run that ends on its last allowed cycle reports DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cycleCnt_q   <= '0;
      dropCnt_q    <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      paritySeen_q <= 1'b0;
      errPc_q      <= '0;
    end else begin
      case (state_q)
        RUN: begin
          cycleCnt_q <= cycleCnt_d;
          if (dropNow && (dropCnt_q != '1)) dropCnt_q <= dropCnt_q + DROP_W'(1);
          if (parity_error && !paritySeen_q) begin
            paritySeen_q <= 1'b1;
            errPc_q      <= pc_value;
          end
          if (pc_value >= END_PC_V) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (cycleCnt_q == CYCLE_LAST) begin
            state_q   <= TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_q      <= RUN;
            cycleCnt_q   <= '0;
            dropCnt_q    <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            paritySeen_q <= 1'b0;
            errPc_q      <= '0;
          end
        end
      endcase
    end
  end

  assign rd.rd_valid = !fifoEmpty;
  assign rd.rd_data  = fifoHead;
  assign rd.count    = fifoCount;

  assign drop_cnt    = dropCnt_q;
  assign state       = state_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign parity_seen = paritySeen_q;
  assign err_pc      = errPc_q;
  assign cycle_cnt   = cycleCnt_q;

endmodule
